branch_predictor_btb: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters. It feeds the IF stage a predicted next PC so that correctly predicted taken branches no longer flush IF/ID and ID/EX. The EX stage resolves each branch, drives the update port, and receives a mispredict flag plus the corrected PC for the redirect/flush logic. It also keeps lookup and mispredict performance counters.

---
 rtl/cpu_bp_pkg.sv | 41 ++++
 rtl/bp_sat_counter.sv | 25 ++
 rtl/branch_predictor_btb.sv | 110 +++++++++++
 tb/tb_branch_predictor_btb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bp_pkg.sv
// Shared types and helpers for the branch predictor: direction-counter encodings,
// the default-configuration BTB entry layout, and PC index/tag extraction.
package cpu_bp_pkg;

    localparam int BP_TAG_W = 8;
    localparam int BP_CTR_W = 2;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        logic [BP_CTR_W-1:0] ctr;
    } btb_entry_t;

    // Counter encodings, returned wide and sized down by the user.
    function automatic logic [31:0] ctr_snt(input int w);
        return 32'd0;
    endfunction

    function automatic logic [31:0] ctr_wnt(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_wt(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] ctr_st(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Word-aligned PCs: the two low bits never select an entry.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w, input int tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a saturating up/down direction counter.
module bp_sat_counter
    import cpu_bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] ctr_nxt
);

    localparam logic [CTR_W-1:0] CTR_SNT = CTR_W'(ctr_snt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_ST  = CTR_W'(ctr_st(CTR_W));

    always_comb begin
        ctr_nxt = ctr;
        if (inc) begin
            if (ctr != CTR_ST)
                ctr_nxt = ctr + 1'b1;
        end else if (ctr != CTR_SNT) begin
            ctr_nxt = ctr - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry direction counters, EX-stage
// update/mispredict detection, and lookup/mispredict performance counters.
module branch_predictor_btb
    import cpu_bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = BP_TAG_W,
    parameter int CTR_W   = BP_CTR_W,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       correct_pc,
    input  logic              inv_all,
    output logic [PERF_W-1:0] perf_lookups,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_wt(CTR_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    entry_t tbl [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    entry_t           lk_e, upd_e;
    logic             upd_hit;
    logic [CTR_W-1:0] ctr_nxt;

    assign lk_idx  = IDX_W'(pc_index(lookup_pc, IDX_W));
    assign lk_tag  = TAG_W'(pc_tag(lookup_pc, IDX_W, TAG_W));
    assign upd_idx = IDX_W'(pc_index(upd_pc, IDX_W));
    assign upd_tag = TAG_W'(pc_tag(upd_pc, IDX_W, TAG_W));

    // Lookup reads registered state only: a same-cycle update is not bypassed.
    assign lk_e        = tbl[lk_idx];
    assign pred_hit    = lk_e.valid && (lk_e.tag == lk_tag);
    assign pred_taken  = pred_hit && lk_e.ctr[CTR_W-1];
    assign pred_target = pred_taken ? lk_e.target : lookup_pc + 32'd4;

    assign mispredict = upd_valid &
                        ((upd_taken != upd_pred_taken) |
                         (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    assign upd_e   = tbl[upd_idx];
    assign upd_hit = upd_e.valid && (upd_e.tag == upd_tag);

    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
        .ctr     (upd_e.ctr),
        .inc     (upd_taken),
        .ctr_nxt (ctr_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid  <= 1'b0;
                tbl[i].tag    <= '0;
                tbl[i].target <= '0;
                tbl[i].ctr    <= CTR_WNT;
            end
            perf_lookups <= '0;
            perf_mispred <= '0;
        end else begin
            if (lookup_valid)
                perf_lookups <= perf_lookups + 1'b1;
            if (mispredict)
                perf_mispred <= perf_mispred + 1'b1;

            // Flush wins over any update; counters and targets survive it.
            if (inv_all) begin
                for (int i = 0; i < ENTRIES; i++)
                    tbl[i].valid <= 1'b0;
            end else if (upd_valid) begin
                if (upd_hit) begin
                    tbl[upd_idx].ctr <= ctr_nxt;
                    if (upd_taken)
                        tbl[upd_idx].target <= upd_target;
                end else if (upd_taken) begin
                    tbl[upd_idx].valid  <= 1'b1;
                    tbl[upd_idx].tag    <= upd_tag;
                    tbl[upd_idx].target <= upd_target;
                    tbl[upd_idx].ctr    <= CTR_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = 32'h0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'h0;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic        inv_all = 1'b0;
    logic [31:0] perf_lookups, perf_mispred;

    int checks = 0;
    int failures = 0;

    branch_predictor_btb #(.ENTRIES(16), .TAG_W(8), .CTR_W(2), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .correct_pc(correct_pc), .inv_all(inv_all),
        .perf_lookups(perf_lookups), .perf_mispred(perf_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: 16 direct-mapped entries, integer counters 0..3.
    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_lk, m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc / 64) % 256);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'h0; m_ctr[i] = 1;
        end
        m_lk = 0; m_mp = 0;
    endtask

    initial model_clear();

    always @(negedge clk) begin
        int i, ui;
        bit e_hit, e_tk, e_mp, u_hit;
        logic [31:0] e_tgt, e_cpc;
        if (!reset) begin
            model_clear();
            chk("rst_hit", {31'b0, pred_hit}, 32'd0);
            chk("rst_taken", {31'b0, pred_taken}, 32'd0);
            chk("rst_target", pred_target, lookup_pc + 32'd4);
            chk("rst_perf_lookups", perf_lookups, 32'd0);
            chk("rst_perf_mispred", perf_mispred, 32'd0);
        end else begin
            i = idx_of(lookup_pc);
            e_hit = m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
            e_tk  = e_hit && (m_ctr[i] >= 2);
            e_tgt = e_tk ? m_tgt[i] : lookup_pc + 32'd4;
            e_mp  = upd_valid && ((upd_taken != upd_pred_taken) ||
                    (upd_taken && upd_pred_taken && upd_target != upd_pred_target));
            e_cpc = upd_taken ? upd_target : upd_pc + 32'd4;
            chk("pred_hit", {31'b0, pred_hit}, {31'b0, e_hit});
            chk("pred_taken", {31'b0, pred_taken}, {31'b0, e_tk});
            chk("pred_target", pred_target, e_tgt);
            chk("mispredict", {31'b0, mispredict}, {31'b0, e_mp});
            if (upd_valid) chk("correct_pc", correct_pc, e_cpc);
            chk("perf_lookups", perf_lookups, m_lk);
            chk("perf_mispred", perf_mispred, m_mp);
            // Apply what the coming clock edge will do.
            if (lookup_valid) m_lk = m_lk + 32'd1;
            if (e_mp) m_mp = m_mp + 32'd1;
            if (inv_all) begin
                for (int k = 0; k < 16; k++) m_valid[k] = 0;
            end else if (upd_valid) begin
                ui = idx_of(upd_pc);
                u_hit = m_valid[ui] && (m_tag[ui] == tag_of(upd_pc));
                if (u_hit) begin
                    m_ctr[ui] = upd_taken ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                                          : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
                    if (upd_taken) m_tgt[ui] = upd_target;
                end else if (upd_taken) begin
                    m_valid[ui] = 1; m_tag[ui] = tag_of(upd_pc);
                    m_tgt[ui] = upd_target; m_ctr[ui] = 2;
                end
            end
        end
    end

    task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic upt, input logic [31:0] uptgt, input logic inv);
        lookup_valid = lv; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_target = utgt; upd_pred_taken = upt;
        upd_pred_target = uptgt; inv_all = inv;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_1010;  // same index as PA, different tag

    initial begin
        #1 reset = 1'b0;
        tick(); tick();
        reset = 1'b1;

        // Empty table after reset.
        drive(1, PA, 0, 0, 0, 0, 0, 0, 0);
        chk("L_reset_hit", {31'b0, pred_hit}, 32'd0);
        chk("L_reset_target", pred_target, 32'h0040_0014);
        chk("L_reset_perf", perf_lookups, 32'd0);
        tick();

        // First taken resolution allocates weakly taken; lookup sees old contents.
        drive(1, PA, 1, PA, 1, 32'h0040_0100, 0, 0, 0);
        chk("L_mp_first", {31'b0, mispredict}, 32'd1);
        chk("L_cpc_first", correct_pc, 32'h0040_0100);
        chk("L_same_cycle_hit", {31'b0, pred_hit}, 32'd0);
        tick();
        drive(1, PA, 0, 0, 0, 0, 0, 0, 0);
        chk("L_alloc_taken", {31'b0, pred_taken}, 32'd1);
        chk("L_alloc_target", pred_target, 32'h0040_0100);
        tick();

        // Two more taken -> 3, then two not-taken -> 1.
        repeat (2) begin
            drive(1, PA, 1, PA, 1, 32'h0040_0100, 1, 32'h0040_0100, 0);
            chk("L_mp_correct", {31'b0, mispredict}, 32'd0);
            tick();
        end
        repeat (2) begin
            drive(1, PA, 1, PA, 0, 0, 1, 32'h0040_0100, 0);
            chk("L_cpc_nt", correct_pc, 32'h0040_0014);
            tick();
        end
        drive(1, PA, 0, 0, 0, 0, 0, 0, 0);
        chk("L_ctr1_taken", {31'b0, pred_taken}, 32'd0);
        chk("L_ctr1_hit", {31'b0, pred_hit}, 32'd1);
        chk("L_ctr1_target", pred_target, 32'h0040_0014);
        tick();

        // Saturate at 0: three not-taken then one taken leaves it not-taken.
        repeat (3) begin drive(1, PA, 1, PA, 0, 0, 0, 0, 0); tick(); end
        drive(1, PA, 1, PA, 1, 32'h0040_0100, 0, 0, 0); tick();
        drive(1, PA, 0, 0, 0, 0, 0, 0, 0);
        chk("L_sat_low", {31'b0, pred_taken}, 32'd0);
        tick();
        // Climb to 3, then a not-taken must still predict taken.
        repeat (4) begin drive(1, PA, 1, PA, 1, 32'h0040_0100, 1, 32'h0040_0100, 0); tick(); end
        drive(1, PA, 1, PA, 0, 0, 1, 32'h0040_0100, 0); tick();
        drive(1, PA, 0, 0, 0, 0, 0, 0, 0);
        chk("L_sat_high", {31'b0, pred_taken}, 32'd1);
        tick();

        // Aliasing and replacement.
        drive(1, PB, 0, 0, 0, 0, 0, 0, 0);
        chk("L_alias_miss", {31'b0, pred_hit}, 32'd0);
        tick();
        drive(1, PB, 1, PB, 1, 32'h0040_1200, 0, 0, 0); tick();
        drive(1, PA, 0, 0, 0, 0, 0, 0, 0);
        chk("L_replaced_miss", {31'b0, pred_hit}, 32'd0);
        tick();

        // Same-cycle lookup/update sees pre-update target.
        drive(1, PB, 1, PB, 1, 32'h0050_0000, 1, 32'h0040_1200, 0);
        chk("L_nobypass_target", pred_target, 32'h0040_1200);
        chk("L_tgt_mp", {31'b0, mispredict}, 32'd1);
        tick();
        drive(1, PB, 0, 0, 0, 0, 0, 0, 0);
        chk("L_new_target", pred_target, 32'h0050_0000);
        tick();

        // Flush overrides a same-cycle update; mispredict still counted by model.
        drive(1, PB, 1, 32'h0000_0020, 1, 32'h0000_0800, 0, 0, 1); tick();
        drive(1, PB, 0, 0, 0, 0, 0, 0, 0);
        chk("L_inv_hit", {31'b0, pred_hit}, 32'd0);
        tick();
        drive(1, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
        chk("L_inv_upd_dropped", {31'b0, pred_hit}, 32'd0);
        tick();

        // Reset mid-update after five lookups.
        drive(0, 0, 1, PA, 1, 32'h0040_0100, 0, 0, 0); tick();
        repeat (5) begin drive(1, PA, 0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(1, PA, 1, PA, 1, 32'h0040_0300, 1, 32'h0040_0100, 0);
        reset = 1'b0;
        #1;
        chk("L_rst_perf", perf_lookups, 32'd0);
        chk("L_rst_hit", {31'b0, pred_hit}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        chk("L_wrap_target", pred_target, 32'h0000_0000);
        chk("L_post_rst_miss", {31'b0, pred_hit}, 32'd0);
        tick();
        drive(1, PA, 0, 0, 0, 0, 0, 0, 0);
        chk("L_post_rst_pa", {31'b0, pred_hit}, 32'd0);
        tick();

        // Randomized traffic over a small PC pool to force hits and aliasing.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] lpc, upc, utgt, ptgt;
            lpc  = 32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            upc  = 32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 50) == 0) upc = 32'hFFFF_FFFC;
            utgt = 32'h0010_0000 | ($urandom_range(0, 7) << 2);
            ptgt = ($urandom_range(0, 1) == 1) ? utgt : 32'h0010_0000 | ($urandom_range(0, 7) << 2);
            drive($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 1) == 1, upc,
                  $urandom_range(0, 2) != 0, utgt, $urandom_range(0, 1) == 1, ptgt,
                  $urandom_range(0, 200) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
